// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
//
// Receive-only PS/2 keyboard front end. It deserialises Set-2 scan-code frames
// and checks the start bit, odd parity and stop bit. Make/break/extended
// prefixes are decoded so that one held-key bit is kept per mapped key.
//
// Ports
//   i_clk         system sampling clock; all logic runs on its posedge
//   i_rst_n       asynchronous active-low reset
//   io_ps2_clk    PS/2 clock from the keyboard (only read, driven 'z)
//   io_ps2_dat    PS/2 data from the keyboard (only read, driven 'z)
//   o_key[31:0]   bit i high while mapped key i is held
//   o_key[32]     registered OR of o_key[31:0]
//   o_code        last accepted scan byte
//   o_code_valid  one-cycle pulse whenever o_code is loaded
//   o_err         one-cycle pulse on parity, framing or timeout error
//   o_state       receiver FSM state (IDLE=0 .. ERR=5)
//
// Handshake: o_code_valid and o_err are single-cycle strobes with no ready.
// o_code and o_key change only on the cycle a strobe is raised, and they hold
// their values at all other times.
// ---------------------------------------------------------------------------
module ps2_key_tracker #(
    parameter int TIMEOUT_CYC = 200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    inout  wire         io_ps2_clk,
    inout  wire         io_ps2_dat,
    output logic [32:0] o_key,
    output logic [7:0]  o_code,
    output logic        o_code_valid,
    output logic        o_err,
    output logic [2:0]  o_state
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // The keyboard owns both lines; this block only listens.
    assign io_ps2_clk = 1'bz;
    assign io_ps2_dat = 1'bz;

    // Set-2 key map. Returns {hit, index}.
    function automatic logic [5:0] key_lookup(input logic [7:0] b);
        logic [5:0] r;
        r = 6'd0;
        case (b)
            8'h15: r = {1'b1, 5'd0};
            8'h1D: r = {1'b1, 5'd1};
            8'h24: r = {1'b1, 5'd2};
            8'h2D: r = {1'b1, 5'd3};
            8'h2C: r = {1'b1, 5'd4};
            8'h35: r = {1'b1, 5'd5};
            8'h3C: r = {1'b1, 5'd6};
            8'h43: r = {1'b1, 5'd7};
            8'h44: r = {1'b1, 5'd8};
            8'h4D: r = {1'b1, 5'd9};
            8'h1C: r = {1'b1, 5'd10};
            8'h1B: r = {1'b1, 5'd11};
            8'h23: r = {1'b1, 5'd12};
            8'h2B: r = {1'b1, 5'd13};
            8'h34: r = {1'b1, 5'd14};
            8'h33: r = {1'b1, 5'd15};
            8'h3B: r = {1'b1, 5'd16};
            8'h42: r = {1'b1, 5'd17};
            8'h4B: r = {1'b1, 5'd18};
            8'h1A: r = {1'b1, 5'd19};
            8'h22: r = {1'b1, 5'd20};
            8'h21: r = {1'b1, 5'd21};
            8'h2A: r = {1'b1, 5'd22};
            8'h32: r = {1'b1, 5'd23};
            8'h31: r = {1'b1, 5'd24};
            8'h3A: r = {1'b1, 5'd25};
            8'h16: r = {1'b1, 5'd26};
            8'h1E: r = {1'b1, 5'd27};
            8'h26: r = {1'b1, 5'd28};
            8'h25: r = {1'b1, 5'd29};
            8'h2E: r = {1'b1, 5'd30};
            8'h36: r = {1'b1, 5'd31};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Synchroniser chains plus one extra stage on the clock for edge detection.
    logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;

    state_t        state_q, state_d;
    logic [10:0]   sr_q, sr_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [31:0]   key_q, key_d;
    logic          any_q, any_d;
    logic [7:0]    code_q, code_d;
    logic          code_valid_q, code_valid_d;
    logic          err_q, err_d;

    logic       fall;
    logic       frame_ok;
    logic [5:0] hit;

    always_comb begin
        clk_s1_d   = io_ps2_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = io_ps2_dat;
        dat_s2_d   = dat_s1_q;
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        key_d        = key_q;
        any_d        = any_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        err_d        = 1'b0;
        hit          = key_lookup(sr_q[8:1]);

        // LSB-first shift. After the 11th edge of a frame the layout is
        // [10]=stop, [9]=parity, [8:1]=data, [0]=start.
        if (fall) begin
            sr_d = {dat_s2_q, sr_q[10:1]};
        end
        // The check uses the post-shift value so that the stop bit on this edge is included.
        frame_ok = (^sr_d[9:1]) & sr_d[10];

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
                // A high bit while idle is just skipped (resync).
                if (fall && !dat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 4'd1;
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (fall) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (state_q == S_DATA) begin
                        if (bit_cnt_q == 4'd8) state_d = S_PARITY;
                    end else if (state_q == S_PARITY) begin
                        state_d = S_STOP;
                    end else begin
                        state_d   = frame_ok ? S_DONE : S_ERR;
                        bit_cnt_d = 4'd0;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT_CYC)) begin
                    state_d   = S_ERR;
                    bit_cnt_d = 4'd0;
                    to_cnt_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                code_d       = sr_q[8:1];
                code_valid_d = 1'b1;
                if (sr_q[8:1] == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (sr_q[8:1] == 8'hE0) begin
                    ext_d = 1'b1;
                end else begin
                    // Extended keys are not mapped: the byte after E0 is dropped.
                    if (!ext_q && hit[5]) begin
                        key_d[hit[4:0]] = ~brk_q;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
                any_d = |key_d;
            end
            S_ERR: begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                brk_d   = 1'b0;
                ext_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            state_q      <= S_IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= 4'd0;
            to_cnt_q     <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            key_q        <= '0;
            any_q        <= 1'b0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            clk_prev_q   <= clk_prev_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            key_q        <= key_d;
            any_q        <= any_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
        end
    end

    assign o_key        = {any_q, key_q};
    assign o_code       = code_q;
    assign o_code_valid = code_valid_q;
    assign o_err        = err_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tracker
//
// Directed bench for ps2_key_tracker. Each byte that is sent pushes the
// expected {o_key, o_code} into exp_q. A monitor on the falling i_clk edge pops
// and compares an entry on every o_code_valid pulse. It also counts o_err
// pulses, and the main sequence checks these against its expected count.
// ---------------------------------------------------------------------------
module tb_ps2_key_tracker;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        ps2_clk_r = 1'b1;
    logic        ps2_dat_r = 1'b1;
    wire         ps2_clk_w;
    wire         ps2_dat_w;
    logic [32:0] o_key;
    logic [7:0]  o_code;
    logic        o_code_valid;
    logic        o_err;
    logic [2:0]  o_state;

    assign ps2_clk_w = ps2_clk_r;
    assign ps2_dat_w = ps2_dat_r;

    ps2_key_tracker dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .io_ps2_clk   (ps2_clk_w),
        .io_ps2_dat   (ps2_dat_w),
        .o_key        (o_key),
        .o_code       (o_code),
        .o_code_valid (o_code_valid),
        .o_err        (o_err),
        .o_state      (o_state)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard state ----------------
    int          compared = 0;
    int          mismatched = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    logic [40:0] exp_q[$];
    logic [40:0] mon_e;

    // Reference model of the held-key bitmap and pending prefixes.
    logic [31:0] m_key = '0;
    logic        m_brk = 1'b0;
    logic        m_ext = 1'b0;
    logic [7:0]  map_tab [32] = '{
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B,
        8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36
    };

    task automatic check(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (o_err) err_seen++;
        if (o_code_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL unexpected_code: observed key %h code %h expected no pulse", o_key, o_code);
            end else begin
                mon_e = exp_q.pop_front();
                check("code_key", {o_key, o_code}, mon_e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par,
                                               input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat_r = bits[i];
            repeat (4) @(posedge i_clk);
            ps2_clk_r = 1'b0;
            repeat (8) @(posedge i_clk);
            ps2_clk_r = 1'b1;
            repeat (4) @(posedge i_clk);
        end
        ps2_dat_r = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int idx;
        idx = -1;
        for (int i = 0; i < 32; i++) if (map_tab[i] == b) idx = i;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            if (!m_ext && idx >= 0) m_key[idx] = ~m_brk;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        exp_q.push_back({|m_key, m_key, b});
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge i_clk);
        check("queue_drain", 41'(exp_q.size()), 41'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_bits(frame_bits(b, 1'b0, 1'b0), 11);
        drain();
    endtask

    task automatic send_bad(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        m_brk = 1'b0;
        m_ext = 1'b0;
        exp_err++;
        send_bits(frame_bits(b, bad_par, bad_stop), 11);
        repeat (10) @(posedge i_clk);
        check("err_count", 41'(err_seen), 41'(exp_err));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_key", 41'(o_key), 41'd0);
        check("rst_code", 41'(o_code), 41'd0);
        check("rst_valid", 41'(o_code_valid), 41'd0);
        check("rst_err", 41'(o_err), 41'd0);
        check("rst_state", 41'(o_state), 41'd0);
        i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);

        // Make / break of 1C
        send_byte(8'h1C);
        @(negedge i_clk);
        check("make_1c", 41'(o_key), 41'(33'h1_0000_0400));
        send_byte(8'hF0);
        send_byte(8'h1C);
        @(negedge i_clk);
        check("break_1c", 41'(o_key), 41'd0);

        // Two keys at the extremes of the map
        send_byte(8'h15);
        send_byte(8'h36);
        @(negedge i_clk);
        check("hold_15_36", 41'(o_key), 41'(33'h1_8000_0001));
        send_byte(8'hF0);
        send_byte(8'h15);
        @(negedge i_clk);
        check("release_15", 41'(o_key), 41'(33'h1_8000_0000));
        send_byte(8'hF0);
        send_byte(8'h36);

        // Parity error, then a clean make and a typematic repeat
        send_bad(8'h1C, 1'b1, 1'b0);
        check("parity_err_key", 41'(o_key), 41'd0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        @(negedge i_clk);
        check("typematic_1c", 41'(o_key), 41'(33'h1_0000_0400));
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Timeout after 5 bits: quiet before ~TIMEOUT_CYC, error after
        send_bits(frame_bits(8'h2D, 1'b0, 1'b0), 5);
        repeat (150) @(posedge i_clk);
        check("no_early_timeout", 41'(err_seen), 41'(exp_err));
        exp_err++;
        m_brk = 1'b0;
        m_ext = 1'b0;
        repeat (100) @(posedge i_clk);
        @(negedge i_clk);
        check("timeout_err", 41'(err_seen), 41'(exp_err));
        check("timeout_idle", 41'(o_state), 41'd0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Extended and unmapped codes leave the map alone and clear flags
        send_byte(8'h15);
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'h76);
        @(negedge i_clk);
        check("ext_unchanged", 41'(o_key), 41'(33'h1_0000_0001));
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        // Pending break is cleared by a framing error
        send_byte(8'hF0);
        send_bad(8'h44, 1'b0, 1'b1);
        send_byte(8'h1C);
        @(negedge i_clk);
        check("err_clears_brk", 41'(o_key), 41'(33'h1_0000_0401));
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h15);

        // Reset in the middle of a 1D frame while bit 1 is held
        send_byte(8'h1D);
        send_bits(frame_bits(8'h1D, 1'b0, 1'b0), 4);
        @(negedge i_clk);
        check("mid_frame_state", 41'(o_state), 41'd1);
        i_rst_n = 1'b0;
        #1;
        check("async_rst_key", 41'(o_key), 41'd0);
        check("async_rst_state", 41'(o_state), 41'd0);
        m_key = '0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);
        send_byte(8'h2D);
        @(negedge i_clk);
        check("post_rst_2d", 41'(o_key), 41'(33'h1_0000_0008));
        send_byte(8'hF0);
        send_byte(8'h2D);

        // Final report
        repeat (20) @(posedge i_clk);
        check("final_queue", 41'(exp_q.size()), 41'd0);
        check("final_err_count", 41'(err_seen), 41'(exp_err));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

PS/2 keyboard front end. It sits directly upstream of the modulator synth and feeds it the 33-bit held-key bitmap. The block receives Set-2 scan-code frames, checks framing and parity, and tracks make/break codes. It maintains one bit per mapped key plus an "any key held" flag. The block is receive-only and never drives the PS/2 lines.

## Interface
Parameters:
- TIMEOUT_CYC, 200 — i_clk cycles without a PS/2 clock falling edge before a partial frame is aborted (2 ms at 100 kHz).

Ports:
- i_clk  in  1  system sampling clock, ≥100 kHz; all logic on posedge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- io_ps2_clk  inout  1  PS/2 clock from the keyboard (10–16.7 kHz); always driven 1'bz.
- io_ps2_dat  inout  1  PS/2 data; always driven 1'bz.
- o_key  out  33  bit i (0–31) is 1 while mapped key i is held; bit 32 = OR of bits 31:0.
- o_code  out  8  last accepted scan byte.
- o_code_valid  out  1  one-cycle pulse when o_code updates.
- o_err  out  1  one-cycle pulse on parity, framing or timeout error.
- o_state  out  3  receiver FSM state, for debug.

## Operation
- Input conditioning: io_ps2_clk and io_ps2_dat each pass through a 2-FF synchronizer. A falling edge is synced clk 1→0 versus its previous sample. Data is sampled on that edge.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1. An 11-bit shift register and a 4-bit counter (0–10) collect the frame.
- FSM encoding: IDLE=0, DATA=1, PARITY=2, STOP=3, DONE=4, ERR=5.
  - IDLE: on an edge with data 0 → DATA. On an edge with data 1 → stay in IDLE; this is not an error.
  - DATA: after 8 edges → PARITY.
  - PARITY: after 1 edge → STOP.
  - STOP: after 1 edge → DONE if XOR(data, parity)=1 and stop=1; otherwise → ERR.
  - DONE → IDLE and ERR → IDLE, each after exactly 1 cycle.
  - Timeout: in DATA, PARITY or STOP, a cycle counter resets on every edge. When it reaches TIMEOUT_CYC the FSM goes → ERR.
- Byte processing in DONE, with pending flags brk and ext:
  - Byte F0: set brk.
  - Byte E0: set ext.
  - Any other byte with ext=1: ignore the byte and clear both flags.
  - Otherwise, look up the byte in the key map. On a hit at index i, set o_key[i] if brk=0 and clear it if brk=1. On a miss, change nothing. Clear both flags in either case.
  - Every DONE byte, prefixes included, loads o_code and pulses o_code_valid.
- ERR: pulse o_err, clear brk and ext, leave o_key unchanged, discard the frame.
- Key map (Set 2, index 0→31):
  - Indices 0–9: 15 1D 24 2D 2C 35 3C 43 44 4D.
  - Indices 10–18: 1C 1B 23 2B 34 33 3B 42 4B.
  - Indices 19–25: 1A 22 21 2A 32 31 3A.
  - Indices 26–31: 16 1E 26 25 2E 36.
- Typematic repeat of a held key: the bit stays 1 and nothing else changes apart from the o_code/o_code_valid update.
- o_key[32] is registered. It updates on the same edge as bits 31:0.

## Timing
- Reset values:
  - o_key=0, o_code=8'h00, o_code_valid=0, o_err=0, o_state=IDLE.
  - brk=0, ext=0, counters=0, synchronizer FFs=1.
- Reset mid-frame discards the partial frame. The block restarts in IDLE, so the remainder of that frame falls into IDLE bit-skipping and any resulting framing error is reported normally.
- Latency: the FSM enters DONE or ERR on the posedge after the synced stop-bit falling edge is detected. o_key, o_code, o_code_valid and o_err update 1 cycle later. They are held stable otherwise.
- The synchronizer adds 2–3 cycles from the pad edge to detection. Total pad-stop-edge → o_key latency ≤5 i_clk cycles.
- Minimum spacing between detected edges is ≥3 i_clk cycles at 100 kHz. The block needs no edge-pair handling.
- Flags persist across frames until consumed by a non-prefix byte or cleared by an error or timeout.

## Test plan
- Make 1C then F0 1C → o_key[10] rises after the 1C frame, with o_key[32]=1. It falls after the F0 1C pair, with o_key=0. o_code_valid pulses 3 times, with o_code=1C, F0, 1C.
- Hold 15 and 36 together, then release 15 → o_key=33'h1_8000_0001, then 33'h1_8000_0000.
- Send 1C with even parity → o_err pulses once, o_key is unchanged, and no o_code_valid pulse occurs. A following valid 1C sets bit 10.
- Stop clock after 5 bits for 250 cycles → o_err pulses at count 200 and the FSM returns to IDLE. The next full frame decodes correctly.
- Send E0 75 and E0 F0 75, plus unmapped 76 → o_key is unchanged and the flags end cleared. Then send F0 and an erroneous frame followed by 1C → bit 10 is set, because brk was cleared by the error.
- Assert reset during the DATA state of a 1D frame while bit 1 is held → o_key=0 and o_state=0 immediately. The next clean frame decodes correctly.
